// File: rtl/xor_mlp_seq_if.sv
// Handshake and configuration bundle for the xor_mlp_seq inference engine.
// master: sample driver / consumer / weight loader; slave: the engine.
interface xor_mlp_seq_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x0;
  logic [DW-1:0] in_x1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pred;
  logic          out_bit;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata;

  modport master (
    output in_valid, in_x0, in_x1, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, out_pred, out_bit
  );

  modport slave (
    input  in_valid, in_x0, in_x1, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_pred, out_bit
  );
endinterface

// File: rtl/xor_mlp_seq.sv
// xor_mlp_seq: sequential 2-2-1 XOR MLP inference with one time-shared MAC.
// Optional feature: define XOR_MLP_SAT_EN to saturate neuron results to DW
// bits instead of two's-complement wrapping.
module xor_mlp_seq #(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  xor_mlp_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MAC, RESP} state_t;

  localparam logic signed [DW-1:0] HALF =
    {{(DW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  state_t state, state_nx;
  logic [2:0] step;

  logic signed [DW-1:0] w00, w01, b0, w10, w11, b1, v0, v1, c;
  logic signed [DW-1:0] x0, x1, h0, h1, pred;
  logic                 pred_bit;

  logic signed [2*DW-1:0] acc, base, prod, prod_sh, sum;
  logic signed [DW-1:0]   mul_a, mul_b, red, relu;

  // Per-step operand selection: even steps start a neuron from its bias,
  // odd steps accumulate onto the running sum.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    base  = '0;
    case (step)
      3'd0: begin mul_a = w00; mul_b = x0; base = {{DW{b0[DW-1]}}, b0}; end
      3'd1: begin mul_a = w01; mul_b = x1; base = acc; end
      3'd2: begin mul_a = w10; mul_b = x0; base = {{DW{b1[DW-1]}}, b1}; end
      3'd3: begin mul_a = w11; mul_b = x1; base = acc; end
      3'd4: begin mul_a = v0;  mul_b = h0; base = {{DW{c[DW-1]}}, c}; end
      3'd5: begin mul_a = v1;  mul_b = h1; base = acc; end
      default: ;
    endcase
  end

  // Full-width signed product, rescaled to the fixed-point grid (floor).
  always_comb begin
    prod    = $signed({{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b});
    prod_sh = prod >>> FRAC;
    sum     = base + prod_sh;
  end

  // Reduce the 2*DW accumulator result to a DW-bit neuron value, then ReLU.
  always_comb begin
`ifdef XOR_MLP_SAT_EN
    if ((sum[2*DW-1:DW-1] == '0) || (sum[2*DW-1:DW-1] == '1))
      red = sum[DW-1:0];
    else if (sum[2*DW-1])
      red = {1'b1, {(DW-1){1'b0}}};
    else
      red = {1'b0, {(DW-1){1'b1}}};
`else
    red = sum[DW-1:0];
`endif
    relu = red[DW-1] ? '0 : red;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = MAC;
      end
      MAC: begin
        if (step == 3'd5) state_nx = RESP;
      end
      RESP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Weight registers: writable only in IDLE so a computation sees fixed values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w00 <= '0; w01 <= '0; b0 <= '0;
      w10 <= '0; w11 <= '0; b1 <= '0;
      v0  <= '0; v1  <= '0; c  <= '0;
    end else if (state == IDLE && bus.cfg_we) begin
      case (bus.cfg_addr)
        4'd0: w00 <= bus.cfg_wdata;
        4'd1: w01 <= bus.cfg_wdata;
        4'd2: b0  <= bus.cfg_wdata;
        4'd3: w10 <= bus.cfg_wdata;
        4'd4: w11 <= bus.cfg_wdata;
        4'd5: b1  <= bus.cfg_wdata;
        4'd6: v0  <= bus.cfg_wdata;
        4'd7: v1  <= bus.cfg_wdata;
        4'd8: c   <= bus.cfg_wdata;
        default: ;
      endcase
    end
  end

  // Datapath: sample capture, accumulation, hidden activations, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0       <= '0;
      x1       <= '0;
      acc      <= '0;
      h0       <= '0;
      h1       <= '0;
      step     <= '0;
      pred     <= '0;
      pred_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x0   <= bus.in_x0;
            x1   <= bus.in_x1;
            step <= '0;
          end
        end
        MAC: begin
          acc  <= sum;
          step <= step + 3'd1;
          if (step == 3'd1) h0 <= relu;
          if (step == 3'd3) h1 <= relu;
          if (step == 3'd5) begin
            pred     <= red;
            pred_bit <= (red >= HALF);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_pred = pred;
  assign bus.out_bit  = pred_bit;

endmodule

// File: tb/tb_xor_mlp_seq.sv
// Scoreboard bench for xor_mlp_seq: stimulus pushes expected results,
// a monitor pops and compares on each output handshake.
module tb_xor_mlp_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [32:0] exp_q[$];

  xor_mlp_seq_if #(.DW(32)) bus ();

  xor_mlp_seq #(.DW(32), .FRAC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted prediction with the scoreboard head.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_pred", bus.out_pred, e[31:0]);
          check("out_bit", {31'd0, bus.out_bit}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    wait_idle();
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic load_xor();
    cfg_write(4'd0, 32'h0001_0000);
    cfg_write(4'd1, 32'h0001_0000);
    cfg_write(4'd2, 32'h0000_0000);
    cfg_write(4'd3, 32'h0001_0000);
    cfg_write(4'd4, 32'h0001_0000);
    cfg_write(4'd5, 32'hFFFF_0000);
    cfg_write(4'd6, 32'h0001_0000);
    cfg_write(4'd7, 32'hFFFE_0000);
    cfg_write(4'd8, 32'h0000_0000);
  endtask

  // Issue one sample, queue its expectation and check the 6-cycle latency.
  task automatic send(input logic [31:0] x0, input logic [31:0] x1,
                      input logic [31:0] pred, input logic pbit);
    int unsigned n;
    exp_q.push_back({pbit, pred});
    bus.in_x0 = x0; bus.in_x1 = x1; bus.in_valid = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, 32'd6);
  endtask

  initial begin
    int unsigned seen;
    bus.in_valid = 1'b0; bus.in_x0 = '0; bus.in_x1 = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_pred", bus.out_pred, 32'd0);
    check("rst_out_bit", {31'd0, bus.out_bit}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero weights
    send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);

    // XOR truth table
    load_xor();
    send(32'h0, 32'h0, 32'h0, 1'b0);
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 1'b1);
    send(32'h0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    send(32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0);

    // Write to c on the same edge as the accept: computation uses new c
    wait_idle();
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd8; bus.cfg_wdata = 32'h0001_0000;
    send(32'h0, 32'h0, 32'h0001_0000, 1'b1);
    cfg_write(4'd8, 32'h0);

    // Back-pressure with an ignored v0 write in RESP
    wait_idle();
    bus.out_ready = 1'b0;
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_pred", bus.out_pred, 32'h0001_0000);
      if (i == 5) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd6; bus.cfg_wdata = 32'h0005_0000;
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(32'h0001_0000, 32'h0, 32'h0001_0000, 1'b1);

    // Overflow of hidden neuron h0
    cfg_write(4'd3, 32'h0);
    cfg_write(4'd4, 32'h0);
    cfg_write(4'd5, 32'h0);
    cfg_write(4'd7, 32'h0);
`ifdef XOR_MLP_SAT_EN
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1);
`else
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 1'b0);
`endif

    // Reset during step 3 aborts the computation and clears weights
    load_xor();
    wait_idle();
    bus.in_x0 = 32'h0001_0000; bus.in_x1 = 32'h0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_pred", bus.out_pred, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", seen, 32'd0);
    send(32'h0001_0000, 32'h0, 32'h0, 1'b0);
    load_xor();
    send(32'h0, 32'h0001_0000, 32'h0001_0000, 1'b1);

    // Drain
    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
